tick_gen_multi: RTL and testbench
=================================

Name: tick_gen_multi

Overview:
Parametrised multi-channel tick generator. It derives NUM_CH independent enable-tick streams from the single system clock. Each channel has a runtime-programmable divisor and produces two outputs: a one-cycle tick pulse and a 50%-duty toggle level. It adds pause, synchronous clear, per-channel disable and asynchronous reset. It feeds the stopwatch/display logic (1 Hz, 2 Hz, 500 Hz scan, blink) and any future rate consumers.

Parameters:
CLK_FREQ, 100_000_000, system clock in Hz; 1_000 under SIMULATION define.
NUM_CH, 4, number of tick channels (1..16).
CNT_W, 32, counter and divisor width per channel.
DIV_INIT, {CLK_FREQ/5, CLK_FREQ/500, CLK_FREQ/2, CLK_FREQ/1}, packed NUM_CH*CNT_W reset divisors; channel 0 is in the LSBs.

Ports:
clk_100mhz  in  1  system clock; all logic is on its rising edge
rst_n  in  1  asynchronous active-low reset
pause  in  1  freezes all counters and levels while high
clear  in  1  synchronous restart of all counters to 0
wr_en  in  1  divisor write strobe
wr_ch  in  $clog2(NUM_CH) (min 1)  channel index to write
wr_div  in  CNT_W  new divisor; 0 disables the channel
tick  out  NUM_CH  one-cycle pulse per channel period
level  out  NUM_CH  toggles on each tick (square wave, period 2*div)
div_rd  out  NUM_CH*CNT_W  current divisor registers (status readback)

Behaviour:
- Reset (rst_n low, asynchronous): cnt[i]=0, div[i]=DIV_INIT[i], tick=0, level=0. Release is synchronous to the clock edge. The first tick of channel i occurs div[i] cycles after the first active edge.
- Channel run condition: run_i = !pause && div[i]!=0.
- Counter: when run_i holds and cnt[i]==div[i]-1, set cnt[i]<=0. Otherwise, when run_i holds, cnt[i]<=cnt[i]+1. When run_i is false, cnt[i] holds.
- tick[i] is registered. It is 1 in the cycle after the wrap edge and 0 otherwise. The period is exactly div[i] cycles.
- div=1 gives tick held high continuously, with level toggling every cycle.
- level[i] <= ~level[i] on every wrap edge.
- pause: counters, levels and divisors hold. tick is forced 0 while pause is high. A tick never fires on the edge where pause is sampled high. After pause drops, counting resumes from the held value, so no phase is lost.
- clear: cnt[*]<=0, tick<=0, level<=0. Divisors are unchanged. clear overrides pause and any wrap on the same edge.
- Divisor write: on wr_en, div[wr_ch]<=wr_div, cnt[wr_ch]<=0, tick[wr_ch]<=0. level is unchanged. Other channels are unaffected. Because the counter restarts, the new period starts cleanly with no short or stretched period.
- wr_ch >= NUM_CH: the write is ignored.
- wr_en together with clear: both apply.
- wr_en together with pause: the write applies; the counter stays at 0 until pause drops.
- wr_div=0: the channel halts. tick=0; level holds its last value.
- Counters never exceed div-1. Comparison is unsigned CNT_W-bit. There is no overflow path.
- div_rd reflects the written value from the cycle after the write edge.
- Outputs are tick enables, not clocks. Consumers gate logic with them on clk_100mhz; they must never be used as clock pins.

Decomposition:
- Package tick_gen_pkg holds:
  - CLK_FREQ_HW=100_000_000 and CLK_FREQ_SIM=1_000;
  - function hz_to_div(freq_clk, hz) returning freq_clk/hz;
  - channel index localparams CH_1HZ=0, CH_2HZ=1, CH_500HZ=2, CH_BLINK=3.
- Sub-module tick_gen_channel: one counter, one divisor register, tick and level. Inputs are clk_100mhz, rst_n, run_en, clear, ld, ld_div and DIV_RST. The top level is a generate loop over NUM_CH plus the write decode and the div_rd packing.

Test Plan:
- Reset with CLK_FREQ=1000, default DIV_INIT (200, 2, 500, 1000); release rst_n and run 2000 cycles -> ticks on ch0 every 1000 cycles, ch1 every 500, ch2 every 2, ch3 every 200. First ch2 tick at cycle 2. level[0] toggles at cycles 1000 and 2000.
- Assert pause for 300 cycles starting at cnt[1]=100 -> no ticks during the pause. The next ch1 tick arrives 400 cycles after pause release. Levels are unchanged during the pause.
- Write wr_ch=3, wr_div=50 mid-period (cnt=120) -> div_rd[3] reads 50 on the next cycle. The ch3 tick follows 50 cycles after the write and repeats every 50. Other channels are undisturbed.
- Write wr_div=0 to ch2, then wr_div=1 -> tick[2] stays 0 with level frozen; after the second write tick[2] is high every cycle. Writing wr_ch=5 with NUM_CH=4 -> no change.
- clear asserted together with pause and with a wrap on ch1 -> all cnt=0, tick=0, level=0 on the next cycle. ch1 re-ticks 500 cycles after clear once pause is low.
- Assert rst_n low asynchronously between clock edges mid-run -> outputs go to 0 immediately and div_rd returns to DIV_INIT without a clock edge.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared constants and helpers for the multi-channel tick generator.
// Clock rates, rate-to-divisor helper, and well-known channel indices.
package tick_gen_pkg;

    localparam int unsigned CLK_FREQ_HW  = 100_000_000;
    localparam int unsigned CLK_FREQ_SIM = 1_000;

    localparam int CH_1HZ   = 0;
    localparam int CH_2HZ   = 1;
    localparam int CH_500HZ = 2;
    localparam int CH_BLINK = 3;

    function automatic int unsigned hz_to_div(
        input int unsigned freq_clk,
        input int unsigned hz
    );
        return freq_clk / hz;
    endfunction

endpackage

// File: rtl/tick_gen_channel.sv
// One tick channel: wrap counter, divisor register, tick pulse, level.
// Ports: clk_100mhz, rst_n, run_en (global run), clear, ld/ld_div
// (divisor load), tick/level outputs, div (divisor readback).
module tick_gen_channel
    import tick_gen_pkg::*;
#(
    parameter int             CNT_W   = 32,
    parameter logic [CNT_W-1:0] DIV_RST = '0
) (
    input  logic             clk_100mhz,
    input  logic             rst_n,
    input  logic             run_en,
    input  logic             clear,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_div,
    output logic             tick,
    output logic             level,
    output logic [CNT_W-1:0] div
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             level_q, level_d;
    logic             run;
    logic             wrap;

    // A zero divisor parks the channel; div_q-1 is never reached then.
    assign run  = run_en && (div_q != '0);
    assign wrap = run && (cnt_q == div_q - CNT_W'(1));

    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        tick_d  = 1'b0;
        level_d = level_q;
        if (clear) begin
            cnt_d   = '0;
            level_d = 1'b0;
            if (ld) div_d = ld_div;
        end else if (ld) begin
            // Restarting the count gives a clean first period.
            div_d = ld_div;
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d   = '0;
            tick_d  = 1'b1;
            level_d = ~level_q;
        end else if (run) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            div_q   <= DIV_RST;
            tick_q  <= 1'b0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            level_q <= level_d;
        end
    end

    assign tick  = tick_q;
    assign level = level_q;
    assign div   = div_q;

endmodule

// File: rtl/tick_gen_multi.sv
// NUM_CH independent tick-enable generators with runtime divisors.
// Ports: clk_100mhz, rst_n, pause, clear, wr_en/wr_ch/wr_div (divisor
// write), tick/level per channel, div_rd packed divisors (ch0 in LSBs).
module tick_gen_multi
    import tick_gen_pkg::*;
#(
`ifdef SIMULATION
    parameter int unsigned CLK_FREQ = CLK_FREQ_SIM,
`else
    parameter int unsigned CLK_FREQ = CLK_FREQ_HW,
`endif
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT =
        (NUM_CH*CNT_W)'({
            CNT_W'(hz_to_div(CLK_FREQ, 5)),
            CNT_W'(hz_to_div(CLK_FREQ, 500)),
            CNT_W'(hz_to_div(CLK_FREQ, 2)),
            CNT_W'(hz_to_div(CLK_FREQ, 1))
        }),
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk_100mhz,
    input  logic                    rst_n,
    input  logic                    pause,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [CH_W-1:0]         wr_ch,
    input  logic [CNT_W-1:0]        wr_div,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       level,
    output logic [NUM_CH*CNT_W-1:0] div_rd
);

    logic run_en;

    assign run_en = ~pause;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic ld;

        // Indices >= NUM_CH match no channel and are dropped.
        assign ld = wr_en && (wr_ch == CH_W'(g));

        tick_gen_channel #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_INIT[g*CNT_W +: CNT_W])
        ) u_ch (
            .clk_100mhz (clk_100mhz),
            .rst_n      (rst_n),
            .run_en     (run_en),
            .clear      (clear),
            .ld         (ld),
            .ld_div     (wr_div),
            .tick       (tick[g]),
            .level      (level[g]),
            .div        (div_rd[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Self-checking bench for tick_gen_multi.
// Directed vectors, scenario sequences and a random run vs a model.
module tb_tick_gen_multi;

    localparam logic [127:0] DINIT =
        {32'd200, 32'd2, 32'd500, 32'd1000};

    logic         clk_100mhz = 1'b0;
    logic         rst_n = 1'b0;
    logic         pause = 1'b0;
    logic         clear = 1'b0;
    logic         wr_en = 1'b0;
    logic [1:0]   wr_ch = '0;
    logic [31:0]  wr_div = '0;
    logic [3:0]   tick;
    logic [3:0]   level;
    logic [127:0] div_rd;

    logic         w2_en = 1'b0;
    logic [1:0]   w2_ch = '0;
    logic [7:0]   w2_div = '0;
    logic [2:0]   tick2;
    logic [2:0]   level2;
    logic [23:0]  div_rd2;

    always #5 clk_100mhz = ~clk_100mhz;

    tick_gen_multi #(
        .CLK_FREQ (1000),
        .NUM_CH   (4),
        .CNT_W    (32)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .rst_n      (rst_n),
        .pause      (pause),
        .clear      (clear),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_div     (wr_div),
        .tick       (tick),
        .level      (level),
        .div_rd     (div_rd)
    );

    tick_gen_multi #(
        .CLK_FREQ (1000),
        .NUM_CH   (3),
        .CNT_W    (8),
        .DIV_INIT (24'h03_02_01)
    ) dut3 (
        .clk_100mhz (clk_100mhz),
        .rst_n      (rst_n),
        .pause      (1'b0),
        .clear      (1'b0),
        .wr_en      (w2_en),
        .wr_ch      (w2_ch),
        .wr_div     (w2_div),
        .tick       (tick2),
        .level      (level2),
        .div_rd     (div_rd2)
    );

    int errs = 0;
    int checks = 0;

    // Model: age counts running edges since the last restart;
    // a tick is due whenever age is a whole multiple of the divisor.
    int unsigned m_div[4];
    longint      m_age[4];
    bit          m_lvl[4];
    bit          m_tick[4];

    task automatic chk(string nm, logic [127:0] got,
                       logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h @%0t",
                     nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_div[c]  = DINIT[c*32 +: 32];
            m_age[c]  = 0;
            m_lvl[c]  = 1'b0;
            m_tick[c] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < 4; c++) begin
            bit wr;
            wr = wr_en && (int'(wr_ch) == c);
            if (clear) begin
                m_age[c]  = 0;
                m_tick[c] = 1'b0;
                m_lvl[c]  = 1'b0;
                if (wr) m_div[c] = wr_div;
            end else if (wr) begin
                m_div[c]  = wr_div;
                m_age[c]  = 0;
                m_tick[c] = 1'b0;
            end else if (!pause && m_div[c] != 0) begin
                m_age[c]++;
                m_tick[c] = (m_age[c] % m_div[c]) == 0;
                if (m_tick[c]) m_lvl[c] = ~m_lvl[c];
            end else begin
                m_tick[c] = 1'b0;
            end
        end
    endtask

    task automatic step();
        logic [3:0]   et;
        logic [3:0]   el;
        logic [127:0] ed;
        @(posedge clk_100mhz);
        model_edge();
        #1;
        for (int c = 0; c < 4; c++) begin
            et[c] = m_tick[c];
            el[c] = m_lvl[c];
            ed[c*32 +: 32] = m_div[c];
        end
        chk("tick", tick, et);
        chk("level", level, el);
        chk("div_rd", div_rd, ed);
    endtask

    task automatic idle();
        pause  = 1'b0;
        clear  = 1'b0;
        wr_en  = 1'b0;
        wr_ch  = '0;
        wr_div = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk_100mhz);
        @(negedge clk_100mhz);
        rst_n = 1'b1;
    endtask

    task automatic wait_tick(int ch, int exp, string nm);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!tick[ch] && n < 2000);
        chk(nm, n, exp);
    endtask

    typedef struct {
        bit        p;
        bit        c;
        bit        w;
        bit [1:0]  ch;
        bit [31:0] dv;
        bit [3:0]  t;
        bit [3:0]  l;
    } vec_t;

    vec_t tv[13];

    initial begin
        int tc[4];

        tv[0]  = '{0, 0, 1, 2'd0, 32'd3, 4'b0000, 4'b0000};
        tv[1]  = '{0, 0, 1, 2'd1, 32'd1, 4'b0100, 4'b0100};
        tv[2]  = '{0, 0, 1, 2'd3, 32'd0, 4'b0010, 4'b0110};
        tv[3]  = '{0, 0, 0, 2'd0, 32'd0, 4'b0111, 4'b0001};
        tv[4]  = '{1, 0, 0, 2'd0, 32'd0, 4'b0000, 4'b0001};
        tv[5]  = '{0, 0, 0, 2'd0, 32'd0, 4'b0010, 4'b0011};
        tv[6]  = '{0, 1, 0, 2'd0, 32'd0, 4'b0000, 4'b0000};
        tv[7]  = '{0, 0, 0, 2'd0, 32'd0, 4'b0010, 4'b0010};
        tv[8]  = '{1, 1, 1, 2'd3, 32'd1, 4'b0000, 4'b0000};
        tv[9]  = '{0, 0, 0, 2'd0, 32'd0, 4'b1010, 4'b1010};
        tv[10] = '{1, 0, 1, 2'd3, 32'd2, 4'b0000, 4'b1010};
        tv[11] = '{0, 0, 0, 2'd0, 32'd0, 4'b0110, 4'b1100};
        tv[12] = '{0, 0, 0, 2'd0, 32'd0, 4'b1011, 4'b0111};

        // Default rates after reset.
        do_reset();
        chk("rst_div", div_rd, DINIT);
        chk("rst_tick", tick, 0);
        tc = '{0, 0, 0, 0};
        for (int i = 0; i < 2000; i++) begin
            step();
            for (int c = 0; c < 4; c++) tc[c] += int'(tick[c]);
            if (i == 0) chk("edge1_tick", tick, 4'b0000);
            if (i == 1) chk("edge2_tick", tick, 4'b0100);
            if (i == 999) chk("lvl0_1000", level[0], 1);
            if (i == 1999) chk("lvl0_2000", level[0], 0);
        end
        chk("cnt_ch0", tc[0], 2);
        chk("cnt_ch1", tc[1], 4);
        chk("cnt_ch2", tc[2], 1000);
        chk("cnt_ch3", tc[3], 10);

        // Pause keeps phase.
        do_reset();
        repeat (100) step();
        pause = 1'b1;
        repeat (300) step();
        chk("pause_lvl", level, 4'b0000);
        pause = 1'b0;
        wait_tick(1, 400, "pause_resume");

        // Mid-period divisor write.
        do_reset();
        repeat (120) step();
        wr_en = 1'b1; wr_ch = 2'd3; wr_div = 32'd50;
        step();
        idle();
        chk("wr_rd3", div_rd[127:96], 50);
        wait_tick(3, 50, "wr_first");
        wait_tick(3, 50, "wr_second");

        // Clear with pause on a ch1 wrap edge.
        do_reset();
        repeat (499) step();
        chk("pre_clr_lvl", level[2], 1);
        clear = 1'b1; pause = 1'b1;
        step();
        idle();
        chk("clr_tick", tick, 0);
        chk("clr_lvl", level, 0);
        wait_tick(1, 500, "clr_retick");

        // Directed vector table.
        do_reset();
        foreach (tv[i]) begin
            pause  = tv[i].p;
            clear  = tv[i].c;
            wr_en  = tv[i].w;
            wr_ch  = tv[i].ch;
            wr_div = tv[i].dv;
            step();
            chk($sformatf("vec%0d_tick", i), tick, tv[i].t);
            chk($sformatf("vec%0d_lvl", i), level, tv[i].l);
        end
        idle();

        // Out-of-range channel on a 3-channel instance.
        chk("n3_rst", div_rd2, 24'h03_02_01);
        w2_en = 1'b1; w2_ch = 2'd3; w2_div = 8'd9;
        step();
        chk("n3_ignore", div_rd2, 24'h03_02_01);
        w2_ch = 2'd1; w2_div = 8'd7;
        step();
        w2_en = 1'b0;
        chk("n3_write", div_rd2, 24'h03_07_01);

        // Random run against the model.
        for (int i = 0; i < 3000; i++) begin
            pause  = ($urandom % 10) == 0;
            clear  = ($urandom % 100) == 0;
            wr_en  = ($urandom % 20) == 0;
            wr_ch  = 2'($urandom % 4);
            wr_div = $urandom % 10;
            step();
        end
        idle();

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tick", tick, 0);
        chk("arst_lvl", level, 0);
        chk("arst_div", div_rd, DINIT);
        @(negedge clk_100mhz);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
